// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480@60), colour type and PMOD pin order.
// Pure declarations: no logic, no latency.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int CNT_W = 10;

  typedef logic [5:0] rgb_t;

  // Bit positions of each colour line within rgb_out as wired to the PMOD
  localparam int PMOD_R1 = 5;
  localparam int PMOD_R0 = 4;
  localparam int PMOD_G1 = 3;
  localparam int PMOD_G0 = 2;
  localparam int PMOD_B1 = 1;
  localparam int PMOD_B0 = 0;

  // Each bar-index bit drives both bits of one colour channel
  function automatic rgb_t bar_colour(input logic [2:0] bar);
    rgb_t c;
    c          = '0;
    c[PMOD_R1] = bar[2];
    c[PMOD_R0] = bar[2];
    c[PMOD_G1] = bar[1];
    c[PMOD_G0] = bar[1];
    c[PMOD_B1] = bar[0];
    c[PMOD_B0] = bar[0];
    return c;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register, DEPTH cycles of latency, no backpressure.
// Synchronous reset loads every stage with RESET_VAL.
module vga_delay_line #(
  parameter int               WIDTH     = 3,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH < 1) begin : g_bad_depth
    $error("vga_delay_line: DEPTH must be at least 1");
  end

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA pixel-timing master: counters to the frame buffer, sync/colour PIPE_LAT+1 cycles later.
// Free-running, no backpressure. Define VGA_TEST_PATTERN_EN to replace colour_in with colour bars.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter int   PIPE_LAT = 1,
  parameter rgb_t FG_RGB   = 6'b111111,
  parameter rgb_t BG_RGB   = 6'b000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             colour_in,
  output logic [CNT_W-1:0] counter_H,
  output logic [CNT_W-1:0] counter_V,
  output logic             line_start,
  output logic             frame_start,
  output logic             h_sync,
  output logic             v_sync,
  output logic             video_active,
  output rgb_t             rgb_out
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOT > 1023 || V_TOT > 1023) begin : g_bad_totals
    $error("vga_timing_gen: timing totals do not fit the 10-bit counters");
  end
  if (PIPE_LAT < 0 || PIPE_LAT > 4) begin : g_bad_lat
    $error("vga_timing_gen: PIPE_LAT must be 0..4");
  end

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign counter_H   = h_cnt;
  assign counter_V   = v_cnt;
  assign line_start  = (h_cnt == '0);
  assign frame_start = (h_cnt == '0) && (v_cnt == '0);

  logic hs_raw;
  logic vs_raw;
  logic act_raw;

  assign hs_raw  = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
  assign vs_raw  = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
  assign act_raw = (h_cnt < H_VIS) && (v_cnt < V_VIS);

  // Bundle order {hs, vs, act[, bar]}; idle value is syncs high, blanked
`ifdef VGA_TEST_PATTERN_EN
  localparam int              PIPE_W    = 6;
  localparam logic [PIPE_W-1:0] PIPE_IDLE = 6'b110_000;
  logic [PIPE_W-1:0] pipe_in;
  logic [PIPE_W-1:0] pipe_out;
  assign pipe_in = {hs_raw, vs_raw, act_raw, h_cnt[8:6]};
`else
  localparam int              PIPE_W    = 3;
  localparam logic [PIPE_W-1:0] PIPE_IDLE = 3'b110;
  logic [PIPE_W-1:0] pipe_in;
  logic [PIPE_W-1:0] pipe_out;
  assign pipe_in = {hs_raw, vs_raw, act_raw};
`endif

  if (PIPE_LAT == 0) begin : g_bypass
    assign pipe_out = pipe_in;
  end else begin : g_pipe
    vga_delay_line #(
      .WIDTH     (PIPE_W),
      .DEPTH     (PIPE_LAT),
      .RESET_VAL (PIPE_IDLE)
    ) u_delay (
      .clk   (clk),
      .reset (reset),
      .d     (pipe_in),
      .q     (pipe_out)
    );
  end

  logic hs_d;
  logic vs_d;
  logic act_d;
  rgb_t pix;

  assign hs_d  = pipe_out[PIPE_W-1];
  assign vs_d  = pipe_out[PIPE_W-2];
  assign act_d = pipe_out[PIPE_W-3];

`ifdef VGA_TEST_PATTERN_EN
  assign pix = bar_colour(pipe_out[2:0]);
`else
  // colour_in arrives PIPE_LAT cycles late, so it lines up with the delayed act bit
  assign pix = colour_in ? FG_RGB : BG_RGB;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      h_sync       <= 1'b1;
      v_sync       <= 1'b1;
      video_active <= 1'b0;
      rgb_out      <= '0;
    end else begin
      h_sync       <= hs_d;
      v_sync       <= vs_d;
      video_active <= act_d;
      rgb_out      <= act_d ? pix : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance (PIPE_LAT=1) and a shrunken one (PIPE_LAT=3).
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int B_HA = 20, B_HF = 3, B_HS = 5, B_HB = 4;
  localparam int B_VA = 10, B_VF = 2, B_VS = 2, B_VB = 3;
  localparam int B_PL = 3;
  localparam int B_HT = B_HA + B_HF + B_HS + B_HB;
  localparam int B_FRAME = B_HT * (B_VA + B_VF + B_VS + B_VB);

`ifdef VGA_TEST_PATTERN_EN
  localparam int RGB_H0   = 6'h00;
  localparam int RGB_H639 = 6'h03;
  localparam int LINE_LIT = 512;
`else
  localparam int RGB_H0   = 6'h3F;
  localparam int RGB_H639 = 6'h3F;
  localparam int LINE_LIT = 640;
`endif

  typedef struct packed {
    logic [9:0] hc;
    logic [9:0] vc;
    logic       ls;
    logic       fs;
    logic       hs;
    logic       vs;
    logic       act;
    logic [5:0] rgb;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t exp;
  } vec_t;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic rst_a = 1'b1, rst_b = 1'b1, col_a = 1'b0, col_b = 1'b0;
  logic [9:0] hc_a, vc_a, hc_b, vc_b;
  logic ls_a, fs_a, hs_a, vs_a, act_a, ls_b, fs_b, hs_b, vs_b, act_b;
  rgb_t rgb_a, rgb_b;

  vga_timing_gen #(.PIPE_LAT(1)) dut_a (
    .clk(clk), .reset(rst_a), .colour_in(col_a),
    .counter_H(hc_a), .counter_V(vc_a), .line_start(ls_a), .frame_start(fs_a),
    .h_sync(hs_a), .v_sync(vs_a), .video_active(act_a), .rgb_out(rgb_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB), .PIPE_LAT(B_PL)
  ) dut_b (
    .clk(clk), .reset(rst_b), .colour_in(col_b),
    .counter_H(hc_b), .counter_V(vc_b), .line_start(ls_b), .frame_start(fs_b),
    .h_sync(hs_b), .v_sync(vs_b), .video_active(act_b), .rgb_out(rgb_b)
  );

  int vectors = 0;
  int miscompares = 0;
  logic hist [0:8191];

  function automatic obs_t mk(input int hc, input int vc, input int ls, input int fs,
                              input int hs, input int vs, input int act, input int rgb);
    obs_t o;
    o.hc = 10'(hc); o.vc = 10'(vc);
    o.ls = (ls != 0); o.fs = (fs != 0); o.hs = (hs != 0); o.vs = (vs != 0);
    o.act = (act != 0); o.rgb = 6'(rgb);
    return o;
  endfunction

  function automatic obs_t obs(input int sel);
    obs_t o;
    if (sel == 0) o = {hc_a, vc_a, ls_a, fs_a, hs_a, vs_a, act_a, rgb_a};
    else          o = {hc_b, vc_b, ls_b, fs_b, hs_b, vs_b, act_b, rgb_b};
    return o;
  endfunction

  // Reference: position in the frame is just elapsed cycles modulo the frame length;
  // the visible outputs show the position PIPE_LAT+1 cycles ago.
  function automatic obs_t model(input int sel, input int c, input logic col);
    int ha, hf, hsw, hb, va, vf, vsw, vb, pl, ht, vt, pos, h, v, d;
    obs_t e;
    if (sel == 0) begin
      ha = 640; hf = 16; hsw = 96; hb = 48; va = 480; vf = 10; vsw = 2; vb = 33; pl = 1;
    end else begin
      ha = B_HA; hf = B_HF; hsw = B_HS; hb = B_HB; va = B_VA; vf = B_VF; vsw = B_VS; vb = B_VB; pl = B_PL;
    end
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    pos = c % (ht * vt);
    e.hc = 10'(pos % ht);
    e.vc = 10'(pos / ht);
    e.ls = (pos % ht) == 0;
    e.fs = (pos == 0);
    d = c - pl - 1;
    if (d < 0) begin
      e.hs = 1'b1; e.vs = 1'b1; e.act = 1'b0; e.rgb = 6'h00;
    end else begin
      pos = d % (ht * vt);
      h = pos % ht;
      v = pos / ht;
      e.hs  = !(h >= ha + hf && h < ha + hf + hsw);
      e.vs  = !(v >= va + vf && v < va + vf + vsw);
      e.act = (h < ha) && (v < va);
`ifdef VGA_TEST_PATTERN_EN
      begin
        int b;
        b = (h / 64) % 8;
        e.rgb = e.act ? 6'(((b / 4) % 2) * 48 + ((b / 2) % 2) * 12 + (b % 2) * 3) : 6'h00;
      end
`else
      e.rgb = e.act ? (col ? 6'h3F : 6'h00) : 6'h00;
`endif
    end
    return e;
  endfunction

  task automatic check_obs(input string name, input int cyc, input obs_t got, input obs_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d: got hc=%0d vc=%0d ls=%b fs=%b hs=%b vs=%b act=%b rgb=%h, expected hc=%0d vc=%0d ls=%b fs=%b hs=%b vs=%b act=%b rgb=%h",
               name, cyc, got.hc, got.vc, got.ls, got.fs, got.hs, got.vs, got.act, got.rgb,
               exp.hc, exp.vc, exp.ls, exp.fs, exp.hs, exp.vs, exp.act, exp.rgb);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic set_col(input int sel, input logic v);
    if (sel == 0) col_a = v; else col_b = v;
  endtask

  // Leaves the caller in cycle 0: just after the last reset edge, reset released
  task automatic do_reset(input int sel, input int n);
    if (sel == 0) rst_a = 1'b1; else rst_b = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check_obs("reset_state", i, obs(sel), mk(0, 0, 1, 1, 1, 1, 0, 0));
    end
    if (sel == 0) rst_a = 1'b0; else rst_b = 1'b0;
  endtask

  task automatic run_model(input int sel, input int n, input string name);
    logic cv;
    check_obs(name, 0, obs(sel), model(sel, 0, 1'b0));
    cv = 1'($urandom_range(0, 1)); set_col(sel, cv); hist[0] = cv;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      check_obs(name, c, obs(sel), model(sel, c, hist[c-1]));
      cv = 1'($urandom_range(0, 1)); set_col(sel, cv); hist[c] = cv;
    end
  endtask

  initial begin
    vec_t tab [16];
    int ti, t_h, t_fall, nlow, nlit, nfs, run, maxrun, nruns, guard;
    logic prev_hs;

    tab[0]  = '{0,    mk(0,   0, 1, 1, 1, 1, 0, 0)};
    tab[1]  = '{1,    mk(1,   0, 0, 0, 1, 1, 0, 0)};
    tab[2]  = '{2,    mk(2,   0, 0, 0, 1, 1, 1, RGB_H0)};
    tab[3]  = '{641,  mk(641, 0, 0, 0, 1, 1, 1, RGB_H639)};
    tab[4]  = '{642,  mk(642, 0, 0, 0, 1, 1, 0, 0)};
    tab[5]  = '{657,  mk(657, 0, 0, 0, 1, 1, 0, 0)};
    tab[6]  = '{658,  mk(658, 0, 0, 0, 0, 1, 0, 0)};
    tab[7]  = '{753,  mk(753, 0, 0, 0, 0, 1, 0, 0)};
    tab[8]  = '{754,  mk(754, 0, 0, 0, 1, 1, 0, 0)};
    tab[9]  = '{799,  mk(799, 0, 0, 0, 1, 1, 0, 0)};
    tab[10] = '{800,  mk(0,   1, 1, 0, 1, 1, 0, 0)};
    tab[11] = '{801,  mk(1,   1, 0, 0, 1, 1, 0, 0)};
    tab[12] = '{802,  mk(2,   1, 0, 0, 1, 1, 1, RGB_H0)};
    tab[13] = '{4799, mk(799, 5, 0, 0, 1, 1, 0, 0)};
    tab[14] = '{4800, mk(0,   6, 1, 0, 1, 1, 0, 0)};
    tab[15] = '{4801, mk(1,   6, 0, 0, 1, 1, 0, 0)};

    // Default timing, colour_in held high: table plus first-line measurements
    col_a = 1'b1;
    do_reset(0, 3);
    ti = 0; t_h = -1; t_fall = -1; nlow = 0; nlit = 0; prev_hs = 1'b1;
    for (int c = 0; c <= 4801; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (ti < 16 && tab[ti].cyc == c) begin
        check_obs("table", c, obs(0), tab[ti].exp);
        ti++;
      end
      if (c < 800) begin
        if (hc_a == 10'd656 && t_h < 0) t_h = c;
        if (!hs_a && prev_hs && t_fall < 0) t_fall = c;
        if (!hs_a) nlow++;
`ifdef VGA_TEST_PATTERN_EN
        if (rgb_a != 6'h00) nlit++;
`else
        if (rgb_a == 6'h3F) nlit++;
`endif
      end
      prev_hs = hs_a;
    end
    check_int("table_entries_hit", ti, 16);
    check_int("hsync_fall_latency_a", t_fall - t_h, 2);
    check_int("hsync_low_cycles_a", nlow, 96);
    check_int("lit_pixels_line0_a", nlit, LINE_LIT);

    // Random colour against the model, then reset in the middle of a visible line
    do_reset(0, 2);
    run_model(0, 1200, "random_a");
    guard = 0;
    while (hc_a != 10'd300 && guard < 1000) begin @(posedge clk); #1; guard++; end
    check_int("reach_h300_a", (hc_a == 10'd300) ? 1 : 0, 1);
    check_int("active_before_reset_a", act_a ? 1 : 0, 1);
    rst_a = 1'b1;
    @(posedge clk); #1;
    check_obs("midline_reset_a", 0, obs(0), mk(0, 0, 1, 1, 1, 1, 0, 0));
    rst_a = 1'b0;
    run_model(0, 900, "after_reset_a");
    rst_a = 1'b1;

    // Shrunken timing, PIPE_LAT=3
    do_reset(1, 3);
    run_model(1, 3 * B_FRAME + 10, "random_b");

    do_reset(1, 1);
    col_b = 1'b1;
    t_h = -1; t_fall = -1; prev_hs = 1'b1; nfs = 0; run = 0; maxrun = 0; nruns = 0;
    for (int c = 0; c < 2 * B_FRAME; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (hc_b == 10'(B_HA + B_HF) && t_h < 0) t_h = c;
      if (!hs_b && prev_hs && t_fall < 0) t_fall = c;
      prev_hs = hs_b;
      if (fs_b) nfs++;
      if (!vs_b) begin
        if (run == 0) nruns++;
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
    end
    check_int("hsync_fall_latency_b", t_fall - t_h, B_PL + 1);
    check_int("vsync_low_run_b", maxrun, B_VS * B_HT);
    check_int("vsync_pulses_b", nruns, 2);
    check_int("frame_starts_b", nfs, 2);

    guard = 0;
    while (!(hc_b == 10'd10 && vc_b == 10'd5) && guard < 2 * B_FRAME) begin
      @(posedge clk); #1; guard++;
    end
    check_int("reach_midframe_b", (hc_b == 10'd10 && vc_b == 10'd5) ? 1 : 0, 1);
    rst_b = 1'b1;
    @(posedge clk); #1;
    check_obs("midframe_reset_b", 0, obs(1), mk(0, 0, 1, 1, 1, 1, 0, 0));
    rst_b = 1'b0;
    run_model(1, 600, "after_reset_b");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Pixel-timing master for the display path; clk is the pixel clock (25.175 MHz nominal).
- Generates counter_H/counter_V for the frame buffer and takes its 1-bit colour back.
- Drives h_sync, v_sync and rgb_out to the VGA PMOD, delay-aligned to the frame buffer's read latency.
- 640x480@60 by default; sync pulses active-low.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
PIPE_LAT, 1, cycles from counter_H/V presented to matching colour_in valid (0..4)
FG_RGB, 6'b111111, rgb_out when colour_in=1
BG_RGB, 6'b000000, rgb_out when colour_in=0 in the active area

Ports:
clk  input  1  pixel clock
reset  input  1  synchronous, active-high reset
colour_in  input  1  pixel colour from the frame buffer, PIPE_LAT cycles after its counters
counter_H  output  10  horizontal pixel counter, 0..H_TOTAL-1
counter_V  output  10  vertical line counter, 0..V_TOTAL-1
line_start  output  1  high for one cycle when counter_H==0
frame_start  output  1  high for one cycle when counter_H==0 and counter_V==0
h_sync  output  1  horizontal sync, active-low, aligned with rgb_out
v_sync  output  1  vertical sync, active-low, aligned with rgb_out
video_active  output  1  high while rgb_out is in the visible area
rgb_out  output  6  {R1,R0,G1,G0,B1,B0}

Behaviour:
- Totals: H_TOTAL = sum of the four H params (800); V_TOTAL = sum of the four V params (525).
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: counter_H=0, counter_V=0, h_sync=1, v_sync=1, video_active=0, rgb_out=0. line_start and frame_start follow the counters, so both read 1 during reset. All delay-pipe stages are flushed to the inactive value.
- Counters:
  - counter_H increments every cycle.
  - At H_TOTAL-1, counter_H wraps to 0 and counter_V increments.
  - At counter_H=H_TOTAL-1 and counter_V=V_TOTAL-1, both wrap to 0.
  - Counters are registered; no enable.
- Raw signals, combinational from the counters:
  - hs_raw = 0 iff H_ACTIVE+H_FP <= counter_H < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs_raw = 0 iff V_ACTIVE+V_FP <= counter_V < V_ACTIVE+V_FP+V_SYNC (490..491).
  - act_raw = counter_H<H_ACTIVE && counter_V<V_ACTIVE.
- Alignment:
  - hs_raw, vs_raw and act_raw pass through a PIPE_LAT-deep shift register, then one output register.
  - rgb_out is registered from the delayed act bit and the live colour_in: act ? (colour_in ? FG_RGB : BG_RGB) : 6'b0.
  - Net latency from counter value to its h_sync/v_sync/video_active/rgb_out is PIPE_LAT+1 cycles.
  - PIPE_LAT=0 means the delay line is bypassed.
- Blanking: rgb_out is forced to 0 whenever the delayed act is 0, regardless of colour_in.
- Width: counters are 10-bit and compare unsigned. Parameter sums above 1023 are illegal; flag them with an elaboration-time check.
- Reset mid-operation: counters return to 0 on the next edge and the pipe flushes in the same edge. Outputs read inactive from the first cycle after reset asserts. No partial lines are emitted after reset releases.
- line_start/frame_start are combinational decodes of the registered counters (no added latency).

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined:
  - colour_in is ignored.
  - Bar index b = counter_H[8:6] is delayed through the same pipe as act_raw.
  - Active-area rgb_out = {b[2],b[2],b[1],b[1],b[0],b[0]}: 64-pixel colour bars, repeating every 512 px.
  - Sync timing is unchanged.
- Undefined: normal colour_in path; no extra logic synthesised.

Decomposition:
- Shared package vga_pkg holds:
  - default timing constants;
  - H_TOTAL/V_TOTAL localparams;
  - rgb_t (6-bit) typedef;
  - PMOD bit-order constants used by the top wrapper.
- One sub-module, vga_delay_line: parameterised WIDTH/DEPTH shift register with synchronous reset to a RESET_VAL parameter. It is instantiated once for the {hs, vs, act[, bar]} bundle.

Test Plan (PIPE_LAT=1 unless stated):
- Reset held 3 cycles: counters=0, h_sync=v_sync=1, rgb_out=0, video_active=0. First cycle after release counter_H=0, next cycle counter_H=1.
- Line wrap: counter_H=799, counter_V=5 -> next cycle counter_H=0, counter_V=6, line_start=1 for exactly one cycle.
- H sync: counter_H reaches 656 at cycle t -> h_sync falls at t+2 and stays low exactly 96 cycles. Repeat with PIPE_LAT=3 -> falls at t+4.
- Frame: v_sync low for exactly 1600 consecutive cycles (lines 490-491). frame_start pulses once per 420000 cycles.
- Colour: colour_in=1 constant -> rgb_out=6'h3F for exactly 640 cycles per line on lines 0..479, 0 elsewhere. colour_in=0 -> rgb_out=0 everywhere.
- Mid-frame reset at counter_H=300, counter_V=200 -> next cycle counters=0, h_sync=v_sync=1, rgb_out=0. With VGA_TEST_PATTERN_EN, line 0 px 64..127 shows 6'b000011.
